jtag_host_engine: RTL and testbench

- FPGA-side JTAG host (initiator) that drives TCK/TMS/TDI toward an external JTAG TAP target and samples TDO from it.
- Accepts reset, IR-scan, DR-scan and idle commands over a valid/ready command channel, then returns captured TDO bits on a valid/ready response channel.
- Sits between on-chip control logic (or a debug bridge) and the JTAG pins. It is the far end of the TAP/test-interface path.

---
 rtl/jtag_host_engine.sv | 345 ++++++++++++++++++++++++++++++++++
 tb/tb_jtag_host_engine.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_host_engine.sv
// -----------------------------------------------------------------------------
// jtag_host_engine
//
// JTAG host (initiator). Drives TCK/TMS/TDI toward an external TAP and samples
// TDO. Commands (RESET, IR_SCAN, DR_SCAN, IDLE) arrive on a valid/ready
// channel; captured TDO bits leave on a valid/ready response channel.
//
// Handshake rule (both channels): a transfer happens on the rising clk edge
// where valid and ready are both high. A valid side, once raised, holds its
// payload stable until that edge.
//
// Ports:
//   clk        system clock
//   trst       asynchronous, active-high reset
//   cmd_valid  command present
//   cmd_ready  engine accepts a command (only in IDLE_WAIT with no response)
//   cmd_op     00 RESET, 01 IR_SCAN, 10 DR_SCAN, 11 IDLE
//   cmd_len    shift bits for scans, TCK count for IDLE
//   cmd_data   TDI bits, LSB shifted first
//   rsp_valid  response available
//   rsp_ready  response consumed
//   rsp_data   captured TDO bits, bit i = i-th shifted bit
//   tck_o      JTAG TCK
//   tms_o      JTAG TMS
//   tdi_o      JTAG TDI
//   tdo_i      JTAG TDO
//   busy       high during the init sequence and from command accept until
//              rsp_valid rises
//   scan_count (only with JTAG_HOST_SCAN_COUNT_EN) count of completed
//              IR/DR scan response handshakes, wraps at 2^32
//
// Optional feature macro: JTAG_HOST_SCAN_COUNT_EN
//
// TCK timing: each TCK period is CLK_DIV clk cycles low then CLK_DIV cycles
// high. The edge that drops TCK (or the command-accept edge for the first
// TCK) is the start of a period; TMS/TDI change there. TDO is sampled on the
// edge that raises TCK.
// -----------------------------------------------------------------------------
module jtag_host_engine #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               trst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i,
  output logic               busy
`ifdef JTAG_HOST_SCAN_COUNT_EN
  ,
  output logic [31:0]        scan_count
`endif
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;
  localparam logic [1:0] OP_IDLE  = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE_WAIT,
    ST_PRE,
    ST_SHIFT,
    ST_POST,
    ST_IDLE_RUN,
    ST_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [LEN_W-1:0]   bit_q, bit_d;
  logic [2:0]         step_q, step_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] mask_q, mask_d;
  logic [MAX_LEN-1:0] rsp_q, rsp_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               is_ir_q, is_ir_d;
  logic               init_resp_q, init_resp_d;

  logic               tck_run;
  logic               tck_rise;
  logic               tck_end;
  logic [LEN_W-1:0]   len_clamp;
  logic [2:0]         pre_last;

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    step_d      = step_q;
    len_d       = len_q;
    data_d      = data_q;
    mask_d      = mask_q;
    rsp_d       = rsp_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    is_ir_d     = is_ir_q;
    init_resp_d = init_resp_q;

    // Scan length clamp: 0 behaves as 1, anything above MAX_LEN saturates.
    if (cmd_len == '0) begin
      len_clamp = LEN_ONE;
    end else if (cmd_len > LEN_MAX) begin
      len_clamp = LEN_MAX;
    end else begin
      len_clamp = cmd_len;
    end

    // IR scans walk Select-DR, Select-IR, Capture-IR, Shift-IR (4 TCKs);
    // DR scans skip Select-IR (3 TCKs).
    pre_last = is_ir_q ? 3'd3 : 3'd2;

    // TCK runs in every pulse-issuing state; IDLE with a zero count issues none.
    tck_run = (state_q == ST_INIT) || (state_q == ST_PRE) ||
              (state_q == ST_SHIFT) || (state_q == ST_POST) ||
              ((state_q == ST_IDLE_RUN) && (len_q != '0));

    tck_rise = tck_run && !tck_q && (div_q == DIV_LAST);
    tck_end  = tck_run &&  tck_q && (div_q == DIV_LAST);

    if (tck_run) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        tck_d = !tck_q;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    // TDO capture: mask_q is one-hot on the bit currently being shifted.
    if (tck_rise && (state_q == ST_SHIFT) && tdo_i) begin
      rsp_d = rsp_q | mask_q;
    end

    case (state_q)
      ST_INIT: begin
        // Five TMS=1 reach Test-Logic-Reset from anywhere; the sixth (0)
        // lands in Run-Test/Idle.
        if (tck_end) begin
          if (step_q == 3'd5) begin
            step_d  = '0;
            state_d = init_resp_q ? ST_RESP : ST_IDLE_WAIT;
          end else begin
            step_d = step_q + 3'd1;
            tms_d  = (step_q < 3'd4);
          end
        end
      end

      ST_IDLE_WAIT: begin
        if (cmd_valid) begin
          rsp_d       = '0;
          mask_d      = MAX_LEN'(1);
          data_d      = cmd_data;
          bit_d       = '0;
          step_d      = '0;
          div_d       = '0;
          tck_d       = 1'b0;
          tdi_d       = 1'b0;
          is_ir_d     = 1'b0;
          init_resp_d = 1'b0;
          case (cmd_op)
            OP_RESET: begin
              state_d     = ST_INIT;
              init_resp_d = 1'b1;
              tms_d       = 1'b1;
            end
            OP_IR: begin
              state_d = ST_PRE;
              is_ir_d = 1'b1;
              len_d   = len_clamp;
              tms_d   = 1'b1;
            end
            OP_DR: begin
              state_d = ST_PRE;
              len_d   = len_clamp;
              tms_d   = 1'b1;
            end
            default: begin
              state_d = ST_IDLE_RUN;
              len_d   = cmd_len;
              tms_d   = 1'b0;
            end
          endcase
        end
      end

      ST_PRE: begin
        if (tck_end) begin
          if (step_q == pre_last) begin
            state_d = ST_SHIFT;
            step_d  = '0;
            bit_d   = '0;
            tms_d   = (len_q == LEN_ONE);
            tdi_d   = data_q[0];
          end else begin
            step_d = step_q + 3'd1;
            tms_d  = is_ir_q && (step_q == 3'd0);
          end
        end
      end

      ST_SHIFT: begin
        if (tck_end) begin
          if (bit_q == (len_q - LEN_ONE)) begin
            // Last shift used TMS=1 (Exit1); next is Update (TMS=1).
            state_d = ST_POST;
            step_d  = '0;
            tms_d   = 1'b1;
            tdi_d   = 1'b0;
          end else begin
            bit_d  = bit_q + LEN_ONE;
            mask_d = mask_q << 1;
            data_d = data_q >> 1;
            tdi_d  = data_d[0];
            tms_d  = ((bit_q + LEN_ONE) == (len_q - LEN_ONE));
          end
        end
      end

      ST_POST: begin
        if (tck_end) begin
          if (step_q == 3'd1) begin
            state_d = ST_RESP;
            step_d  = '0;
          end else begin
            step_d = 3'd1;
            tms_d  = 1'b0;
          end
        end
      end

      ST_IDLE_RUN: begin
        if (len_q == '0) begin
          state_d = ST_RESP;
        end else if (tck_end) begin
          if (bit_q == (len_q - LEN_ONE)) begin
            state_d = ST_RESP;
          end else begin
            bit_d = bit_q + LEN_ONE;
          end
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE_WAIT;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge trst) begin
    if (trst) begin
      state_q     <= ST_INIT;
      div_q       <= '0;
      bit_q       <= '0;
      step_q      <= '0;
      len_q       <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      rsp_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      is_ir_q     <= 1'b0;
      init_resp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      step_q      <= step_d;
      len_q       <= len_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      rsp_q       <= rsp_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      is_ir_q     <= is_ir_d;
      init_resp_q <= init_resp_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE_WAIT);
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE_WAIT) && (state_q != ST_RESP);
  assign rsp_data  = rsp_q;
  assign tck_o     = tck_q;
  assign tms_o     = tms_q;
  assign tdi_o     = tdi_q;

`ifdef JTAG_HOST_SCAN_COUNT_EN
  // Counts scan responses only; RESET and IDLE handshakes are ignored.
  logic        is_scan_q;
  logic [31:0] scan_cnt_q;

  always_ff @(posedge clk or posedge trst) begin
    if (trst) begin
      is_scan_q  <= 1'b0;
      scan_cnt_q <= '0;
    end else begin
      if ((state_q == ST_IDLE_WAIT) && cmd_valid) begin
        is_scan_q <= (cmd_op == OP_IR) || (cmd_op == OP_DR);
      end
      if ((state_q == ST_RESP) && rsp_ready && is_scan_q) begin
        scan_cnt_q <= scan_cnt_q + 32'd1;
      end
    end
  end

  assign scan_count = scan_cnt_q;
`endif

endmodule

// File: tb/tb_jtag_host_engine.sv
// -----------------------------------------------------------------------------
// tb_jtag_host_engine
//
// Directed plus randomized commands against jtag_host_engine. The reference
// is an IEEE 1149.1 TAP state-machine model that watches TCK/TMS/TDI, plus
// TMS/latency/data expectations derived from the command rules. TDO is driven
// by the bench: loopback (TDO=TDI), a BYPASS register, or random bits.
// -----------------------------------------------------------------------------
module tb_jtag_host_engine;

  localparam int CLK_DIV = 4;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  // ---------------------------------------------------------------- clock/reset
  logic               clk = 1'b0;
  logic               trst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;
  logic               tck_o;
  logic               tms_o;
  logic               tdi_o;
  wire                tdo_i;
  logic               busy;
`ifdef JTAG_HOST_SCAN_COUNT_EN
  logic [31:0]        scan_count;
`endif

  always #5 clk = ~clk;

  jtag_host_engine #(
    .CLK_DIV (CLK_DIV),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) dut (
    .clk       (clk),
    .trst      (trst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .tck_o     (tck_o),
    .tms_o     (tms_o),
    .tdi_o     (tdi_o),
    .tdo_i     (tdo_i),
    .busy      (busy)
`ifdef JTAG_HOST_SCAN_COUNT_EN
    ,
    .scan_count(scan_count)
`endif
  );

  // ---------------------------------------------------------------- bookkeeping
  int checks = 0;
  int errors = 0;
  logic [MAX_LEN-1:0] exp_q[$];
  logic [31:0] scan_model = 32'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- TAP model
  typedef enum int {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_t;

  function automatic tap_t tap_next(input tap_t s, input logic tms);
    case (s)
      TLR:     return tms ? TLR    : RTI;
      RTI:     return tms ? SEL_DR : RTI;
      SEL_DR:  return tms ? SEL_IR : CAP_DR;
      CAP_DR:  return tms ? EX1_DR : SH_DR;
      SH_DR:   return tms ? EX1_DR : SH_DR;
      EX1_DR:  return tms ? UPD_DR : PA_DR;
      PA_DR:   return tms ? EX2_DR : PA_DR;
      EX2_DR:  return tms ? UPD_DR : SH_DR;
      UPD_DR:  return tms ? SEL_DR : RTI;
      SEL_IR:  return tms ? TLR    : CAP_IR;
      CAP_IR:  return tms ? EX1_IR : SH_IR;
      SH_IR:   return tms ? EX1_IR : SH_IR;
      EX1_IR:  return tms ? UPD_IR : PA_IR;
      PA_IR:   return tms ? EX2_IR : PA_IR;
      EX2_IR:  return tms ? UPD_IR : SH_IR;
      default: return tms ? SEL_DR : RTI;
    endcase
  endfunction

  tap_t        tap = TLR;
  int          tck_cnt = 0;
  logic [63:0] tms_log = '0;
  logic [63:0] shin = '0;
  logic [63:0] shout = '0;
  int          sh_idx = 0;
  int          ir_sh = 0;
  int          dr_sh = 0;
  int          mode = 0;      // 0 loopback, 1 bypass, 2 random
  logic        byp = 1'b0;
  logic        tdo_rand = 1'b0;

  assign tdo_i = (mode == 0) ? tdi_o : (mode == 1) ? byp : tdo_rand;

  always @(negedge tck_o) tdo_rand <= 1'($urandom_range(0, 1));

  always @(posedge tck_o) begin
    tck_cnt++;
    tms_log = {tms_log[62:0], tms_o};
    if (tap == SH_IR || tap == SH_DR) begin
      if (sh_idx < 64) begin
        shin[sh_idx]  = tdi_o;
        shout[sh_idx] = tdo_i;
      end
      sh_idx++;
      if (tap == SH_IR) ir_sh++;
      else dr_sh++;
    end
    if (tap == CAP_DR) byp = 1'b0;
    else if (tap == SH_DR) byp = tdi_o;
    tap = tap_next(tap, tms_o);
  end

  // TCK high phase must always be CLK_DIV clk cycles.
  int hi_cnt = 0;
  always @(negedge clk) begin
    if (trst) begin
      hi_cnt = 0;
    end else if (tck_o) begin
      hi_cnt++;
    end else if (hi_cnt != 0) begin
      check("tck_high_width", 64'(hi_cnt), 64'(CLK_DIV));
      hi_cnt = 0;
    end
  end

  // ---------------------------------------------------------------- model helpers
  logic [63:0] exp_tms;
  int          exp_cnt;

  task automatic add_tms(input logic b);
    exp_tms = {exp_tms[62:0], b};
    exp_cnt++;
  endtask

  task automatic clear_logs();
    tck_cnt = 0;
    tms_log = '0;
    shin    = '0;
    shout   = '0;
    sh_idx  = 0;
    ir_sh   = 0;
    dr_sh   = 0;
  endtask

  // ---------------------------------------------------------------- driver tasks
  // Releases trst and checks the autonomous 6-TCK init sequence.
  task automatic init_check();
    int   cyc;
    logic saw_rsp;
    clear_logs();
    saw_rsp = 1'b0;
    @(negedge clk);
    trst = 1'b0;
    cyc  = 0;
    while (!cmd_ready && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) saw_rsp = 1'b1;
    end
    check("init_cycles", 64'(cyc), 64'(12 * CLK_DIV));
    check("init_tck_count", 64'(tck_cnt), 64'd6);
    check("init_tms", tms_log, 64'b111110);
    check("init_tap_rti", 64'(int'(tap)), 64'(int'(RTI)));
    check("init_busy", 64'(busy), 64'd0);
    check("init_no_rsp", 64'(saw_rsp), 64'd0);
    check("init_tck_low", 64'(tck_o), 64'd0);
  endtask

  task automatic wait_ready(input string tag);
    int cyc;
    cyc = 0;
    while (!cmd_ready && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, 64'(cmd_ready), 64'd1);
  endtask

  task automatic run_cmd(input logic [1:0] op, input int len,
                         input logic [MAX_LEN-1:0] data, input int tmode,
                         input int hold);
    int                 n;
    int                 cyc;
    int                 exp_lat;
    bit                 is_scan;
    logic [MAX_LEN-1:0] msk;
    logic [MAX_LEN-1:0] exp_rsp;
    logic [MAX_LEN-1:0] want;

    is_scan = (op == 2'b01) || (op == 2'b10);
    n = len;
    if (is_scan) begin
      if (n == 0) n = 1;
      if (n > MAX_LEN) n = MAX_LEN;
    end

    exp_tms = '0;
    exp_cnt = 0;
    case (op)
      2'b00: begin
        for (int i = 0; i < 5; i++) add_tms(1'b1);
        add_tms(1'b0);
      end
      2'b01, 2'b10: begin
        add_tms(1'b1);
        if (op == 2'b01) add_tms(1'b1);
        add_tms(1'b0);
        add_tms(1'b0);
        for (int i = 0; i < n; i++) add_tms(i == n - 1);
        add_tms(1'b1);
        add_tms(1'b0);
      end
      default: begin
        for (int i = 0; i < n; i++) add_tms(1'b0);
      end
    endcase
    exp_lat = (exp_cnt == 0) ? 1 : 2 * CLK_DIV * exp_cnt;
    msk = (n >= MAX_LEN) ? '1 : MAX_LEN'((64'd1 << n) - 64'd1);

    mode = tmode;
    wait_ready("cmd_ready_idle");
    clear_logs();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = LEN_W'(len);
    cmd_data  = data;
    @(posedge clk);
    @(negedge clk);
    // Scramble the command bus: the engine must have latched the fields.
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_len   = LEN_W'($urandom);
    cmd_data  = $urandom;
    check("busy_after_accept", 64'(busy), 64'd1);
    check("ready_low_after_accept", 64'(cmd_ready), 64'd0);

    cyc = 0;
    while (!rsp_valid && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("rsp_latency", 64'(cyc), 64'(exp_lat));
    check("tck_count", 64'(tck_cnt), 64'(exp_cnt));
    check("tms_sequence", tms_log, exp_tms);
    check("tap_end_rti", 64'(int'(tap)), 64'(int'(RTI)));
    check("tck_low_at_rsp", 64'(tck_o), 64'd0);
    check("busy_low_at_rsp", 64'(busy), 64'd0);
    check("ready_low_at_rsp", 64'(cmd_ready), 64'd0);
    check("ir_shift_count", 64'(ir_sh), (op == 2'b01) ? 64'(n) : 64'd0);
    check("dr_shift_count", 64'(dr_sh), (op == 2'b10) ? 64'(n) : 64'd0);

    if (!is_scan) begin
      exp_rsp = '0;
    end else begin
      check("tdi_bits", 64'(shin[MAX_LEN-1:0] & msk), 64'(data & msk));
      case (tmode)
        0:       exp_rsp = data & msk;
        1:       exp_rsp = (data << 1) & msk;
        default: exp_rsp = shout[MAX_LEN-1:0] & msk;
      endcase
    end
    exp_q.push_back(exp_rsp);
    want = exp_q.pop_front();
    check("rsp_data", 64'(rsp_data), 64'(want));

    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check("hold_rsp_data", 64'(rsp_data), 64'(want));
      check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      check("hold_no_tck", 64'(tck_cnt), 64'(exp_cnt));
    end

    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_cleared", 64'(rsp_valid), 64'd0);
    check("cmd_ready_after_hs", 64'(cmd_ready), 64'd1);
    check("busy_after_hs", 64'(busy), 64'd0);
    if (is_scan) scan_model = scan_model + 32'd1;
`ifdef JTAG_HOST_SCAN_COUNT_EN
    check("scan_count", 64'(scan_count), 64'(scan_model));
`endif
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no completion, required completion within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [1:0] rop;
    int         rlen;
    int         rmode;
    int         cyc;

    trst      = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_len   = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    repeat (5) @(negedge clk);

    check("rst_tck", 64'(tck_o), 64'd0);
    check("rst_tms", 64'(tms_o), 64'd1);
    check("rst_tdi", 64'(tdi_o), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
`ifdef JTAG_HOST_SCAN_COUNT_EN
    check("rst_scan_count", 64'(scan_count), 64'd0);
`endif

    init_check();

    // Directed cases.
    run_cmd(2'b01, 4, 32'h0000_000A, 0, 0);    // IR, loopback
    run_cmd(2'b10, 32, 32'hDEAD_BEEF, 1, 0);   // DR, bypass
    run_cmd(2'b11, 10, 32'h0, 0, 0);           // IDLE 10
    run_cmd(2'b11, 0, 32'h0, 0, 0);            // IDLE 0
    run_cmd(2'b00, 0, 32'h0, 0, 0);            // RESET op
    run_cmd(2'b10, 8, 32'h0000_00C5, 1, 20);   // DR with held response
    run_cmd(2'b10, 0, 32'hFFFF_FFFF, 0, 0);    // len 0 -> 1
    run_cmd(2'b01, 40, 32'h1234_5678, 2, 0);   // len 40 -> 32
    run_cmd(2'b10, 1, 32'h0000_0001, 2, 0);    // single-bit shift

    // Randomized commands.
    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      if (rop == 2'b11) rlen = $urandom_range(0, 12);
      else rlen = $urandom_range(0, 40);
      if (rop == 2'b10) rmode = $urandom_range(0, 2);
      else rmode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      run_cmd(rop, rlen, $urandom, rmode, $urandom_range(0, 3));
    end

    // Reset in the middle of a 16-bit DR scan, during shift bit 5.
    mode = 2;
    wait_ready("cmd_ready_before_abort");
    clear_logs();
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_len   = LEN_W'(16);
    cmd_data  = $urandom;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 0;
    while (!(sh_idx >= 6 && tck_o) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_at_bit5", 64'(sh_idx), 64'd6);
    #2;
    trst = 1'b1;
    #1;
    check("abort_tck", 64'(tck_o), 64'd0);
    check("abort_tms", 64'(tms_o), 64'd1);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd1);
    check("abort_cmd_ready", 64'(cmd_ready), 64'd0);
    scan_model = 32'd0;
    repeat (3) @(negedge clk);
    check("abort_rsp_data", 64'(rsp_data), 64'd0);
    init_check();
    check("abort_no_pending", 64'(exp_q.size()), 64'd0);
`ifdef JTAG_HOST_SCAN_COUNT_EN
    check("abort_scan_count", 64'(scan_count), 64'd0);
`endif

    run_cmd(2'b01, 6, 32'h0000_0027, 0, 0);    // recovery after abort

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
